// File: rtl/mpeg_fifo_pkg.sv
// Shared helpers for the MPEG stream FIFO: lane placement and pointer widths.
package mpeg_fifo_pkg;

    localparam int MIN_RATIO = 2;
    localparam int MAX_RATIO = 8;

    function automatic int lane_offset(input int k, input int ratio,
                                       input int w, input bit big_endian);
        return big_endian ? (ratio - 1 - k) * w : k * w;
    endfunction

    function automatic int lane_ptr_w(input int depth_words, input int ratio);
        return $clog2(depth_words * ratio);
    endfunction

    function automatic int word_ptr_w(input int depth_words);
        return $clog2(depth_words);
    endfunction

    function automatic int level_w(input int depth_words, input int ratio);
        return $clog2(depth_words * ratio) + 1;
    endfunction

endpackage

// File: rtl/mpeg_fifo_mixed_ram.sv
// Mixed-width simple dual-port RAM: lane-wide writes, word-wide registered reads.
module mpeg_fifo_mixed_ram
    import mpeg_fifo_pkg::*;
#(
    parameter int W          = 8,
    parameter int RATIO      = 4,
    parameter int DEPTH      = 8192,
    parameter bit BIG_ENDIAN = 1'b1,
    localparam int AW        = word_ptr_w(DEPTH),
    localparam int LAW       = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [LAW-1:0]       wlane,
    input  logic [W-1:0]         wdata,
    input  logic                 re,
    input  logic [AW-1:0]        raddr,
    output logic [RATIO*W-1:0]   q
);

    logic [RATIO-1:0][W-1:0] mem [DEPTH];

    // Byte-enable style write keeps the array mappable onto block RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < RATIO; k++) begin
            if (we && wlane == LAW'(k))
                mem[waddr][lane_offset(k, RATIO, 1, BIG_ENDIAN)] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re)
            q <= mem[raddr];
    end

endmodule

// File: rtl/mpeg_stream_fifo.sv
// Byte-in, word-out show-ahead stream FIFO feeding the MPEG bitstream parser.
module mpeg_stream_fifo
    import mpeg_fifo_pkg::*;
#(
    parameter int WR_WIDTH    = 8,
    parameter int RATIO       = 4,
    parameter int DEPTH_WORDS = 8192,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  wr_en,
    input  logic [WR_WIDTH-1:0]                   wr_data,
    output logic                                  wr_full,
    output logic                                  overflow,
    output logic                                  rd_valid,
    input  logic                                  rd_ready,
    output logic [WR_WIDTH*RATIO-1:0]             rd_data,
    output logic [$clog2(DEPTH_WORDS*RATIO):0]    lane_level
);

    localparam int CAP = DEPTH_WORDS * RATIO;
    localparam int LW  = lane_ptr_w(DEPTH_WORDS, RATIO);
    localparam int AW  = word_ptr_w(DEPTH_WORDS);
    localparam int LAW = $clog2(RATIO);
    localparam int LVW = level_w(DEPTH_WORDS, RATIO);
    localparam int RWW = AW + 1;

    logic [LW-1:0]             wptr;
    logic [AW-1:0]             rptr;
    logic [RWW-1:0]            ram_words;
    logic                      q_valid;
    logic [WR_WIDTH*RATIO-1:0] q;
    logic                      clr;
    logic                      wr_acc;
    logic                      word_done;
    logic                      pop;
    logic                      out_ready;
    logic                      issue;

    assign clr       = reset || flush;
    assign wr_full   = (lane_level == LVW'(CAP));
    assign wr_acc    = wr_en && !wr_full && !clr;
    assign word_done = wr_acc && (wptr[LAW-1:0] == LAW'(RATIO - 1));
    assign pop       = rd_valid && rd_ready;
    assign out_ready = !rd_valid || pop;
    // Only complete words are counted in ram_words, so a read never sees a partial word.
    assign issue     = !clr && (ram_words != '0) && (!q_valid || out_ready);

    mpeg_fifo_mixed_ram #(
        .W          (WR_WIDTH),
        .RATIO      (RATIO),
        .DEPTH      (DEPTH_WORDS),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[LW-1:LAW]),
        .wlane (wptr[LAW-1:0]),
        .wdata (wr_data),
        .re    (issue),
        .raddr (rptr),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (!flush && wr_en && wr_full)
            overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_words  <= '0;
            lane_level <= '0;
            q_valid    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + LW'(1);
            if (issue)
                rptr <= rptr + AW'(1);
            ram_words  <= ram_words + RWW'(word_done) - RWW'(issue);
            lane_level <= lane_level + LVW'(wr_acc)
                          - (pop ? LVW'(RATIO) : LVW'(0));
            q_valid    <= issue || (q_valid && !out_ready);
            if (out_ready) begin
                rd_valid <= q_valid;
                if (q_valid)
                    rd_data <= q;
            end
        end
    end

endmodule

// File: tb/tb_mpeg_stream_fifo.sv
// Randomised scoreboard bench: two FIFOs (big/little endian) share one stimulus stream.
module tb_mpeg_stream_fifo;

    localparam int W   = 8;
    localparam int R   = 4;
    localparam int D   = 4;
    localparam int CAP = D * R;
    localparam int LVW = $clog2(CAP) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           flush = 1'b0;
    logic           wr_en = 1'b0;
    logic [W-1:0]   wr_data = '0;
    logic           rd_ready = 1'b0;

    logic           full_be, full_le, ovf_be, ovf_le, vld_be, vld_le;
    logic [W*R-1:0] data_be, data_le;
    logic [LVW-1:0] lvl_be, lvl_le;

    always #5 clk = ~clk;

    mpeg_stream_fifo #(.WR_WIDTH(W), .RATIO(R), .DEPTH_WORDS(D), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(full_be), .overflow(ovf_be), .rd_valid(vld_be), .rd_ready(rd_ready),
        .rd_data(data_be), .lane_level(lvl_be));

    mpeg_stream_fifo #(.WR_WIDTH(W), .RATIO(R), .DEPTH_WORDS(D), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(full_le), .overflow(ovf_le), .rd_valid(vld_le), .rd_ready(rd_ready),
        .rd_data(data_le), .lane_level(lvl_le));

    typedef struct {
        logic [W*R-1:0] be;
        logic [W*R-1:0] le;
        int             done;
    } word_t;

    word_t        expq[$];
    logic [W-1:0] part[$];
    int           m_level = 0;
    bit           m_ovf = 1'b0;
    bit           just_cleared = 1'b1;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare against the lane-queue model, then apply this cycle's inputs.
    always @(negedge clk) begin
        bit   exp_valid;
        bit   acc;
        word_t wd;
        exp_valid = (expq.size() > 0) && (expq[0].done <= cyc - 2);
        check("level_be", 64'(lvl_be), 64'(m_level));
        check("level_le", 64'(lvl_le), 64'(m_level));
        check("full_be", 64'(full_be), 64'(m_level == CAP));
        check("full_le", 64'(full_le), 64'(m_level == CAP));
        check("ovf_be", 64'(ovf_be), 64'(m_ovf));
        check("ovf_le", 64'(ovf_le), 64'(m_ovf));
        check("valid_be", 64'(vld_be), 64'(exp_valid));
        check("valid_le", 64'(vld_le), 64'(exp_valid));
        if (exp_valid) begin
            check("data_be", 64'(data_be), 64'(expq[0].be));
            check("data_le", 64'(data_le), 64'(expq[0].le));
        end else if (just_cleared) begin
            check("clr_data_be", 64'(data_be), 64'd0);
            check("clr_data_le", 64'(data_le), 64'd0);
        end
        just_cleared = 1'b0;

        if (reset || flush) begin
            expq.delete();
            part.delete();
            m_level = 0;
            just_cleared = 1'b1;
            if (reset)
                m_ovf = 1'b0;
        end else begin
            acc = wr_en && (m_level < CAP);
            if (wr_en && m_level == CAP)
                m_ovf = 1'b1;
            if (exp_valid && rd_ready) begin
                void'(expq.pop_front());
                m_level -= R;
            end
            if (acc) begin
                part.push_back(wr_data);
                m_level += 1;
                if (part.size() == R) begin
                    wd.be = {part[0], part[1], part[2], part[3]};
                    wd.le = {part[3], part[2], part[1], part[0]};
                    wd.done = cyc + 1;
                    expq.push_back(wd);
                    part.delete();
                end
            end
        end
    end

    task automatic step(input logic fl, input logic we, input logic [W-1:0] wd, input logic rr);
        flush = fl;
        wr_en = we;
        wr_data = wd;
        rd_ready = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Eight lanes 01..08 held, then drained.
        for (int i = 1; i <= 8; i++) step(0, 1, W'(i), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Fill to capacity plus one overflowing write, then drain.
        for (int i = 0; i < CAP + 1; i++) step(0, 1, W'(8'h10 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

        // Continuous streaming over three capacities.
        for (int i = 0; i < 3 * CAP; i++) step(0, 1, W'($urandom), 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Random write/ready pattern with stalls.
        for (int i = 0; i < 400; i++)
            step(0, $urandom_range(0, 99) < 70, W'($urandom), 1'($urandom));

        // Flush with two words plus three lanes held and a concurrent write.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 11; i++) step(0, 1, W'(8'h30 + i), 0);
        step(1, 1, 8'hAA, 0);
        for (int i = 0; i < 8; i++) step(0, 1, W'(8'h50 + i), 1);

        // Bounded drain of whatever complete words remain.
        n = 0;
        while (expq.size() > 0 && n < 200) begin
            step(0, 0, 0, 1);
            n++;
        end
        checks++;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words left, expected 0", expq.size());
        end
        step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
